// File: rtl/pc_seq_if.sv
// Sequencer bus: control-unit opcode/interrupt inputs and PC/stack status outputs.
// The master side is the control unit; the slave side is pc_sequencer.
interface pc_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int IRQ_N  = 4
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic               stall;
    logic [2:0]         op;
    logic [ADDR_W-1:0]  target;
    logic [IRQ_N-1:0]   irqReq;
    logic [IRQ_N-1:0]   irqMask;
    logic               clrFlags;
    logic [ADDR_W-1:0]  pc;
    logic [IRQ_N-1:0]   irqAck;
    logic               intEnable;
    logic               inIsr;
    logic [DEPTH_W-1:0] depth;
    logic               overflow;
    logic               underflow;

    modport master (
        output stall, op, target, irqReq, irqMask, clrFlags,
        input  pc, irqAck, intEnable, inIsr, depth, overflow, underflow
    );

    modport slave (
        input  stall, op, target, irqReq, irqMask, clrFlags,
        output pc, irqAck, intEnable, inIsr, depth, overflow, underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter, circular return-address stack and prioritised vectored interrupt entry.
// Optional macro PC_SEQ_STACK_GUARD_EN: stack faults vector to FAULT_VEC instead of wrapping.
module pc_sequencer #(
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH      = 8,
    parameter int                IRQ_N      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = 16'h0000,
    parameter logic [ADDR_W-1:0] IRQ_BASE   = 16'h00F0,
    parameter int                VEC_STRIDE = 4,
    parameter logic [ADDR_W-1:0] FAULT_VEC  = 16'h00EC
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_seq_if.slave    bus
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);
    localparam logic [PTR_W-1:0]   LAST = PTR_W'(DEPTH - 1);

`ifdef PC_SEQ_STACK_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_HOLD = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_RETI = 3'b101;
    localparam logic [2:0] OP_EI   = 3'b110;
    localparam logic [2:0] OP_DI   = 3'b111;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [IRQ_N-1:0]   ack_q, ack_d;
    logic               ie_q, ie_d;
    logic               isr_q, isr_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [DEPTH_W-1:0] depth_q;
    logic [PTR_W-1:0]   sp_q;
    logic [ADDR_W-1:0]  stk_q [DEPTH];

    logic [IRQ_N-1:0]   pend, onehot;
    logic [ADDR_W-1:0]  vec, pc_inc, top;
    logic [PTR_W-1:0]   sp_prev;
    logic               accept, push, pop, push_ok, pop_ok;

    // sp_q is the next free slot; when full it points at the oldest entry
    assign sp_prev = (sp_q == '0) ? LAST : sp_q - 1'b1;
    assign top     = stk_q[sp_prev];
    assign pc_inc  = pc_q + 1'b1;

    always_comb begin
        pend   = bus.irqReq & bus.irqMask;
        vec    = IRQ_BASE;
        onehot = '0;
        // Descending scan so the lowest pending channel is the one left standing
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pend[i]) begin
                vec    = IRQ_BASE + ADDR_W'(i * VEC_STRIDE);
                onehot = IRQ_N'(1) << i;
            end
        end
        accept = !bus.stall && ie_q && (bus.op == OP_NEXT) && (|pend);

        pc_d  = pc_q;
        ie_d  = ie_q;
        isr_d = isr_q;
        ack_d = '0;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;

        if (!bus.stall) begin
            ovf_d = ovf_q & ~bus.clrFlags;
            unf_d = unf_q & ~bus.clrFlags;
            if (accept) begin
                push  = 1'b1;
                pc_d  = vec;
                ie_d  = 1'b0;
                isr_d = 1'b1;
                ack_d = onehot;
            end else begin
                case (bus.op)
                    OP_NEXT: pc_d = pc_inc;
                    OP_HOLD: pc_d = pc_q;
                    OP_JUMP: pc_d = bus.target;
                    OP_CALL: begin push = 1'b1; pc_d = bus.target; end
                    OP_RET:  pop = 1'b1;
                    OP_RETI: begin pop = 1'b1; ie_d = 1'b1; isr_d = 1'b0; end
                    OP_EI:   begin ie_d = 1'b1; pc_d = pc_inc; end
                    OP_DI:   begin ie_d = 1'b0; pc_d = pc_inc; end
                    default: pc_d = pc_q;
                endcase
            end

            if (pop) begin
                if (depth_q == '0) begin
                    unf_d = 1'b1;
                    pc_d  = GUARD_EN ? FAULT_VEC : RESET_VEC;
                    if (GUARD_EN) ie_d = 1'b0;
                end else begin
                    pc_d = top;
                end
            end
            if (push && depth_q == FULL) begin
                ovf_d = 1'b1;
                if (GUARD_EN) begin
                    pc_d = FAULT_VEC;
                    ie_d = 1'b0;
                end
            end
        end

        push_ok = push && !(GUARD_EN && depth_q == FULL);
        pop_ok  = pop && (depth_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            ack_q   <= '0;
            ie_q    <= 1'b0;
            isr_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            depth_q <= '0;
            sp_q    <= '0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ack_q <= ack_d;
            ie_q  <= ie_d;
            isr_q <= isr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (push_ok) begin
                stk_q[sp_q] <= pc_inc;
                sp_q        <= (sp_q == LAST) ? '0 : sp_q + 1'b1;
                if (depth_q != FULL) depth_q <= depth_q + 1'b1;
            end else if (pop_ok) begin
                sp_q    <= sp_prev;
                depth_q <= depth_q - 1'b1;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.irqAck    = ack_q;
    assign bus.intEnable = ie_q;
    assign bus.inIsr     = isr_q;
    assign bus.depth     = depth_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule
